// File: rtl/prm_edge_check_sched.sv
// Walks one roadmap edge in 2^LOG2_SAMPLES equal steps, issuing each interpolated pose
// to the shared collision checker and stopping at the first colliding sample.
module prm_edge_check_sched #(
  parameter int STEPPERS_NUM = 6,
  parameter int LOG2_SAMPLES = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      abort,
  input  logic [32*STEPPERS_NUM-1:0] startPose,
  input  logic [32*STEPPERS_NUM-1:0] endPose,
  output logic                      chk_valid,
  input  logic                      chk_ready,
  output logic [32*STEPPERS_NUM-1:0] chk_pose,
  input  logic                      res_valid,
  input  logic                      res_hit,
  output logic                      busy,
  output logic                      done,
  output logic                      edgeFree,
  output logic [10:0]               hitIndex
);

  localparam int PW = 32 * STEPPERS_NUM;
  localparam int KW = LOG2_SAMPLES + 1;
  localparam logic [KW-1:0] LastK = {1'b1, {LOG2_SAMPLES{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StDone,
    StDrain
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   startPose_q, startPose_d;
  logic [PW-1:0]   endPose_q, endPose_d;
  logic [PW-1:0]   delta_q, delta_d;
  logic [PW-1:0]   pose_q, pose_d;
  logic [PW-1:0]   advPose;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   kNext;
  logic            edgeFree_q, edgeFree_d;
  logic [10:0]     hitIndex_q, hitIndex_d;
  logic            handshake;
  logic            lastSample;

  assign handshake  = chk_valid && chk_ready;
  assign lastSample = (k_q == LastK);
  assign kNext      = k_q + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // abort outranks every other event; results arriving alongside an abort are dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = abort ? StIdle : StIssue;
      StIssue: begin
        if (abort)          state_d = handshake ? StDrain : StIdle;
        else if (handshake) state_d = StWait;
      end
      StWait: begin
        if (abort)          state_d = res_valid ? StIdle : StDrain;
        else if (res_valid) state_d = (res_hit || lastSample) ? StDone : StIssue;
      end
      StDone:  state_d = StIdle;
      StDrain: if (res_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    chk_valid = (state_q == StIssue);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

  always_comb begin
    advPose = '0;
    for (int j = 0; j < STEPPERS_NUM; j++) begin
      advPose[32*j +: 32] = pose_q[32*j +: 32] + delta_q[32*j +: 32];
    end
  end

  // The final sample is forced to endPose so truncated step sizes never miss the endpoint
  always_comb begin
    startPose_d = startPose_q;
    endPose_d   = endPose_q;
    delta_d     = delta_q;
    pose_d      = pose_q;
    k_d         = k_q;
    edgeFree_d  = edgeFree_q;
    hitIndex_d  = hitIndex_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          startPose_d = startPose;
          endPose_d   = endPose;
          edgeFree_d  = 1'b0;
          hitIndex_d  = '0;
        end
      end
      StLoad: begin
        for (int j = 0; j < STEPPERS_NUM; j++) begin
          delta_d[32*j +: 32] = 32'($signed(endPose_q[32*j +: 32] - startPose_q[32*j +: 32])
                                    >>> LOG2_SAMPLES);
        end
        pose_d = startPose_q;
        k_d    = '0;
      end
      StWait: begin
        if (res_valid && !abort) begin
          if (res_hit) begin
            hitIndex_d = 11'(k_q);
            edgeFree_d = 1'b0;
          end else if (lastSample) begin
            edgeFree_d = 1'b1;
            hitIndex_d = '0;
          end else begin
            k_d    = kNext;
            pose_d = (kNext == LastK) ? endPose_q : advPose;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      startPose_q <= '0;
      endPose_q   <= '0;
      delta_q     <= '0;
      pose_q      <= '0;
      k_q         <= '0;
      edgeFree_q  <= 1'b0;
      hitIndex_q  <= '0;
    end else begin
      startPose_q <= startPose_d;
      endPose_q   <= endPose_d;
      delta_q     <= delta_d;
      pose_q      <= pose_d;
      k_q         <= k_d;
      edgeFree_q  <= edgeFree_d;
      hitIndex_q  <= hitIndex_d;
    end
  end

  assign chk_pose = pose_q;
  assign edgeFree = edgeFree_q;
  assign hitIndex = hitIndex_q;

endmodule

// File: tb/tb_prm_edge_check_sched.sv
// Bench for prm_edge_check_sched: table vectors, abort/reset sequences and random edges
// against a closed-form interpolation model with a randomized checker responder.
`timescale 1ns/1ps
module tb_prm_edge_check_sched;

  localparam int SN = 6;
  localparam int L2 = 4;
  localparam int NS = 1 << L2;
  localparam int PW = 32 * SN;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start, abort, chk_ready, res_valid, res_hit;
  logic [PW-1:0] startPose, endPose;
  logic          chk_valid, busy, done, edgeFree;
  logic [PW-1:0] chk_pose;
  logic [10:0]   hitIndex;

  int            passCount  = 0;
  int            totalCount = 0;
  logic [31:0]   obsJ0 [0:NS];
  logic          doneFlag;
  logic [PW-1:0] sp, ep;

  typedef struct {
    logic [31:0] s0;
    logic [31:0] e0;
    int          hitAt;
    int          stall;
    logic        expFree;
    int          expHit;
    int          expQ;
    int          probeK;
    logic [31:0] probeVal;
  } vec_t;

  vec_t vecs [7];

  prm_edge_check_sched #(.STEPPERS_NUM(SN), .LOG2_SAMPLES(L2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .abort     (abort),
    .startPose (startPose),
    .endPose   (endPose),
    .chk_valid (chk_valid),
    .chk_ready (chk_ready),
    .chk_pose  (chk_pose),
    .res_valid (res_valid),
    .res_hit   (res_hit),
    .busy      (busy),
    .done      (done),
    .edgeFree  (edgeFree),
    .hitIndex  (hitIndex)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic tickA();
    @(negedge CLK);
    doneFlag = doneFlag | done;
  endtask

  // Sample k lies k steps of floor((e-s)/2^L2) from s, except the last which is exactly e
  function automatic logic [31:0] modelJoint(input logic [31:0] s, input logic [31:0] e, input int k);
    logic [31:0] d;
    if (k == NS) return e;
    d = 32'($signed(e - s) >>> L2);
    return s + 32'(k) * d;
  endfunction

  function automatic logic [PW-1:0] modelPose(input logic [PW-1:0] s, input logic [PW-1:0] e, input int k);
    logic [PW-1:0] p;
    p = '0;
    for (int j = 0; j < SN; j++) p[32*j +: 32] = modelJoint(s[32*j +: 32], e[32*j +: 32], k);
    return p;
  endfunction

  // Runs one edge to completion, acting as the collision checker; hit is reported on query hitAt
  task automatic applyStimulus(input logic [PW-1:0] s, input logic [PW-1:0] e, input int hitAt,
                               input int readyPct, input int maxLat, input int stallFirst,
                               output int nQ, output logic freeO, output logic [10:0] hitO);
    int cycles, lat, stall;
    logic pending, planHit, holding, doneSeen, busyBad, stableBad, overlapBad;
    logic [PW-1:0] heldPose;
    nQ = 0; cycles = 0; lat = 0; stall = stallFirst;
    pending = 0; planHit = 0; holding = 0; doneSeen = 0;
    busyBad = 0; stableBad = 0; overlapBad = 0; heldPose = '0;
    for (int i = 0; i <= NS; i++) obsJ0[i] = 32'hDEADBEEF;
    startPose = s; endPose = e; start = 1'b1;
    tick();
    start = 1'b0;
    while (!doneSeen && cycles < 2000) begin
      cycles++;
      chk_ready = 1'b0; res_valid = 1'b0; res_hit = 1'b0;
      if (!busy) busyBad = 1'b1;
      if (done) begin
        doneSeen = 1'b1;
      end else if (pending) begin
        if (chk_valid) overlapBad = 1'b1;
        if (lat == 0) begin
          res_valid = 1'b1; res_hit = planHit; pending = 1'b0;
        end else begin
          lat--;
        end
      end else if (chk_valid) begin
        if (holding && chk_pose !== heldPose) stableBad = 1'b1;
        if (stall > 0) begin
          stall--;
          chk_ready = 1'b0;
        end else begin
          chk_ready = ($urandom_range(99) < readyPct);
        end
        if (chk_ready) begin
          if (nQ <= NS) begin
            checkOutput($sformatf("pose[%0d]", nQ), chk_pose, modelPose(s, e, nQ));
            obsJ0[nQ] = chk_pose[31:0];
          end
          planHit = (nQ == hitAt);
          nQ++;
          pending = 1'b1;
          lat = $urandom_range(maxLat);
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          heldPose = chk_pose;
          if (stall > 0 || $urandom_range(2) == 0) begin
            res_valid = 1'b1; res_hit = 1'b1;
          end
        end
      end
      if (!doneSeen) tick();
    end
    checkOutput("doneSeen", doneSeen, 1'b1);
    checkOutput("busyThroughout", busyBad, 1'b0);
    checkOutput("poseStableUnderStall", stableBad, 1'b0);
    checkOutput("oneOutstanding", overlapBad, 1'b0);
    freeO = edgeFree;
    hitO  = hitIndex;
    if (doneSeen) begin
      tick();
      checkOutput("donePulseOneCycle", done, 1'b0);
      checkOutput("idleAfterDone", busy, 1'b0);
    end else begin
      RST = 1'b1; tick(); RST = 1'b0; tick();
    end
  endtask

  task automatic drainSeq(input string name);
    checkOutput({name, ":drain"}, {busy, chk_valid}, 2'b10);
    start = 1'b1;
    tickA();
    start = 1'b0;
    checkOutput({name, ":drainHold"}, busy, 1'b1);
    tickA();
    checkOutput({name, ":drainHold2"}, busy, 1'b1);
    res_valid = 1'b1; res_hit = 1'b0;
    tickA();
    res_valid = 1'b0;
    checkOutput({name, ":drainExit"}, busy, 1'b0);
    tickA();
    checkOutput({name, ":startIgnored"}, busy, 1'b0);
  endtask

  // mode: 0 LOAD, 1 ISSUE no handshake, 2 ISSUE with handshake, 3 WAIT no result, 4 WAIT with result
  task automatic abortCase(input int mode, input string name);
    doneFlag = 1'b0;
    startPose = '0; startPose[31:0] = 32'd40;
    endPose   = '0; endPose[31:0]   = 32'd200;
    start = 1'b1;
    tickA();
    start = 1'b0;
    checkOutput({name, ":inLoad"}, {busy, chk_valid}, 2'b10);
    if (mode == 0) begin
      abort = 1'b1; tickA(); abort = 1'b0;
      checkOutput({name, ":idle"}, busy, 1'b0);
    end else begin
      tickA();
      checkOutput({name, ":issue"}, chk_valid, 1'b1);
      if (mode == 1) begin
        abort = 1'b1; chk_ready = 1'b0; tickA(); abort = 1'b0;
        checkOutput({name, ":idle"}, busy, 1'b0);
      end else if (mode == 2) begin
        abort = 1'b1; chk_ready = 1'b1; tickA(); abort = 1'b0; chk_ready = 1'b0;
        drainSeq(name);
      end else begin
        chk_ready = 1'b1; tickA(); chk_ready = 1'b0;
        checkOutput({name, ":wait"}, {busy, chk_valid}, 2'b10);
        if (mode == 3) begin
          abort = 1'b1; tickA(); abort = 1'b0;
          drainSeq(name);
        end else begin
          abort = 1'b1; res_valid = 1'b1; res_hit = 1'b1;
          tickA();
          abort = 1'b0; res_valid = 1'b0; res_hit = 1'b0;
          checkOutput({name, ":idle"}, busy, 1'b0);
        end
      end
    end
    checkOutput({name, ":noDone"}, doneFlag, 1'b0);
    checkOutput({name, ":edgeFree"}, edgeFree, 1'b0);
    checkOutput({name, ":hitIndex"}, hitIndex, 11'd0);
  endtask

  initial begin
    int nQ, expQ, expHit, hitAt;
    logic freeO, expFree;
    logic [10:0] hitO;

    vecs[0] = '{32'd0,   32'd160, 99, 0, 1'b1, 0,  17, 16, 32'd160};
    vecs[1] = '{32'd0,   32'd160, 5,  0, 1'b0, 5,  6,  5,  32'd50};
    vecs[2] = '{32'd100, 32'd0,   99, 3, 1'b1, 0,  17, 15, 32'hFFFFFFFB};
    vecs[3] = '{32'd100, 32'd0,   99, 0, 1'b1, 0,  17, 14, 32'd2};
    vecs[4] = '{32'd100, 32'd0,   99, 0, 1'b1, 0,  17, 16, 32'd0};
    vecs[5] = '{32'd0,   32'd100, 16, 0, 1'b0, 16, 17, 15, 32'd90};
    vecs[6] = '{32'd0,   32'd100, 0,  0, 1'b0, 0,  1,  0,  32'd0};

    RST = 1'b1; start = 0; abort = 0; chk_ready = 0; res_valid = 0; res_hit = 0;
    startPose = '0; endPose = '0; doneFlag = 0;
    tick(); tick();
    checkOutput("reset:flags", {busy, done, chk_valid, edgeFree, hitIndex}, '0);
    checkOutput("reset:pose", chk_pose, '0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      sp = '0; sp[31:0] = vecs[i].s0;
      ep = '0; ep[31:0] = vecs[i].e0;
      applyStimulus(sp, ep, vecs[i].hitAt, (i == 0) ? 100 : 70, (i == 0) ? 0 : 2,
                    vecs[i].stall, nQ, freeO, hitO);
      checkOutput($sformatf("vec%0d:queries", i), nQ, vecs[i].expQ);
      checkOutput($sformatf("vec%0d:edgeFree", i), freeO, vecs[i].expFree);
      checkOutput($sformatf("vec%0d:hitIndex", i), hitO, 11'(vecs[i].expHit));
      checkOutput($sformatf("vec%0d:sample%0d", i, vecs[i].probeK), obsJ0[vecs[i].probeK],
                  vecs[i].probeVal);
    end

    abortCase(0, "abortLoad");
    abortCase(1, "abortIssue");
    abortCase(2, "abortIssueHs");
    abortCase(3, "abortWait");
    abortCase(4, "abortWaitRes");

    // Asynchronous reset while a query is outstanding, then a clean rerun
    sp = '0; sp[31:0] = 32'd1000; sp[63:32] = 32'hFFFFFF00;
    ep = '0; ep[31:0] = 32'd2000; ep[63:32] = 32'd300;
    startPose = sp; endPose = ep; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_ready = 1'b1;
    tick(); chk_ready = 1'b0;
    checkOutput("rst:inWait", {busy, chk_valid}, 2'b10);
    #2 RST = 1'b1;
    #1;
    checkOutput("rst:asyncFlags", {busy, done, chk_valid, edgeFree, hitIndex}, '0);
    checkOutput("rst:asyncPose", chk_pose, '0);
    tick(); RST = 1'b0; tick();
    applyStimulus(sp, ep, 99, 80, 1, 0, nQ, freeO, hitO);
    checkOutput("rst:rerunQueries", nQ, NS + 1);
    checkOutput("rst:rerunFree", freeO, 1'b1);
    checkOutput("rst:rerunHit", hitO, 11'd0);

    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < SN; j++) begin
        if (i % 2 == 0) begin
          sp[32*j +: 32] = $urandom;
          ep[32*j +: 32] = $urandom;
        end else begin
          sp[32*j +: 32] = 32'($signed($urandom_range(4000)) - 2000);
          ep[32*j +: 32] = 32'($signed($urandom_range(4000)) - 2000);
        end
      end
      hitAt = $urandom_range(NS + 4);
      if (hitAt <= NS) begin
        expQ = hitAt + 1; expFree = 1'b0; expHit = hitAt;
      end else begin
        expQ = NS + 1; expFree = 1'b1; expHit = 0;
      end
      applyStimulus(sp, ep, hitAt, $urandom_range(100, 30), $urandom_range(3),
                    $urandom_range(2), nQ, freeO, hitO);
      checkOutput($sformatf("rand%0d:queries", i), nQ, expQ);
      checkOutput($sformatf("rand%0d:edgeFree", i), freeO, expFree);
      checkOutput($sformatf("rand%0d:hitIndex", i), hitO, 11'(expHit));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
